jit_emit_seq: RTL and testbench
===============================

// Module: jit_emit_seq
// PURPOSE
//  Template emitter for the bytecode JIT. Accepts one JVM opcode per handshake and walks its
//  ARM template: drives ROM indices into com_rom (combinational, 3-bit in, 32-bit out).
//  Streams the returned words, with a code-buffer address, to the code-memory writer.
//  Sits between the bytecode fetch stage (upstream) and the code buffer (downstream).
// PARAMETERS
//  ROM_AW   3   width of com_rom index (rom_addr)
//  WORD_W   32  ARM instruction word width
//  CODE_AW  10  code-buffer address width (2^CODE_AW words)
// PORTS
//  clk           in   1        clock, all state on rising edge
//  rst           in   1        synchronous reset, active-high
//  flush         in   1        sync: abort sequence, code_ptr:=0, clear full/err
//  bc_valid      in   1        opcode offered by fetch stage
//  bc_opcode     in   8        JVM opcode
//  bc_ready      out  1        emitter can accept an opcode
//  rom_addr      out  ROM_AW   index into com_rom
//  rom_data      in   WORD_W   com_rom output for rom_addr (same cycle)
//  emit_valid    out  1        emit_data/emit_addr valid
//  emit_ready    in   1        code buffer accepts the word
//  emit_addr     out  CODE_AW  word address = code_ptr
//  emit_data     out  WORD_W   = rom_data while emit_valid
//  code_full     out  1        sticky: last buffer word written
//  err_unsup     out  1        sticky: unsupported opcode consumed
// BEHAVIOUR
//  Reset (rst=1, sync): state=IDLE, step=0, code_ptr=0, rom_addr=0, code_full=0, err_unsup=0.
//  Outputs after reset: bc_ready=1, emit_valid=0. Priority: rst > flush > handshakes.
//  Template table, fixed in-block, up to 3 ROM indices per opcode:
//   0x00 nop  -> len 0
//   0x60 iadd -> {1,2,3} (E83D0003, E0800001, E9AD0001)
//   0x64 isub -> {1,4,3} (E83D0003, E0400001, E9AD0001)
//   other     -> unsupported
//  FSM: IDLE, EMIT.
//   IDLE: bc_ready = ~code_full.
//    Accept on bc_valid&bc_ready: latch index list + len, step:=0, rom_addr:=idx[0].
//    Then -> EMIT if len>0. nop or unsupported stays IDLE (consumed in 1 cycle).
//    Unsupported additionally sets err_unsup; nothing emitted.
//   EMIT: bc_ready=0, emit_valid=1, emit_addr=code_ptr, emit_data=rom_data.
//    emit_valid=1 exactly when state==EMIT, so it deasserts together with code_full on the last word.
//    emit_ready=0: hold rom_addr, code_ptr, step (data stable, no drop).
//    emit_ready=1: code_ptr:=code_ptr+1.
//     If step==len-1: -> IDLE, else step++ and rom_addr:=idx[step+1].
//    One word per cycle at full throughput. Opcode accept to first emit_valid = 1 cycle.
//    No bubble between words of one template.
//    IDLE->accept is possible the cycle after the last word (no back-to-back overlap).
//  Buffer end: code_ptr does not wrap.
//   Word accepted at code_ptr==2^CODE_AW-1: word is written, code_full:=1, code_ptr holds.
//   Any remaining template words are dropped and state -> IDLE.
//   While code_full: bc_ready=0, emit_valid=0, until flush or rst.
//  flush: state:=IDLE, step:=0, code_ptr:=0, code_full:=0, err_unsup:=0.
//   Any in-flight word is not written. flush with bc_valid in the same cycle: opcode not accepted.
//  rst mid-sequence: same as reset. Partial template is not completed.
//  err_unsup does not block acceptance; it only flags.
// TESTING
//  Single iadd: bc_opcode=0x60, emit_ready=1 -> 3 cycles emit_valid.
//   Data E83D0003/E0800001/E9AD0001 at addr 0,1,2; then bc_ready=1.
//  Backpressure: isub, emit_ready low 2 cycles on word 1.
//   E0400001 held stable at addr 1; sequence resumes; no word lost or duplicated.
//  nop + unsupported: 0x00 then 0xB1 -> each consumed in 1 cycle, no emit_valid.
//   err_unsup=1 after 0xB1; code_ptr stays 0.
//  Buffer end (CODE_AW=2): iadd, iadd -> words at 0,1,2,3; code_full=1 after addr 3.
//   Third word of 2nd iadd dropped; bc_ready=0 until flush.
//  Flush mid-EMIT: flush during word 1 of iadd.
//   Next cycle IDLE, code_ptr=0, emit_valid=0; next iadd starts at addr 0.
//  Reset mid-EMIT with emit_ready=0: all outputs at reset values next cycle.

Source files
------------

// File: rtl/jit_emit_seq.sv
// Template emitter: expands one JVM opcode into a fixed ARM word sequence
// fetched from com_rom and streamed to the code buffer with its address.
module jit_emit_seq #(
    parameter int ROM_AW  = 3,
    parameter int WORD_W  = 32,
    parameter int CODE_AW = 10
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               flush,
    input  logic               bc_valid,
    input  logic [7:0]         bc_opcode,
    output logic               bc_ready,
    output logic [ROM_AW-1:0]  rom_addr,
    input  logic [WORD_W-1:0]  rom_data,
    output logic               emit_valid,
    input  logic               emit_ready,
    output logic [CODE_AW-1:0] emit_addr,
    output logic [WORD_W-1:0]  emit_data,
    output logic               code_full,
    output logic               err_unsup
);

    typedef enum logic {
        S_IDLE,
        S_EMIT
    } state_t;

    state_t              r_state;
    logic [1:0]          r_step;
    logic [1:0]          r_len;
    logic [ROM_AW-1:0]   r_rom_addr;
    logic [ROM_AW-1:0]   r_nxt1;
    logic [ROM_AW-1:0]   r_nxt2;
    logic [CODE_AW-1:0]  r_ptr;
    logic                r_full;
    logic                r_err;

    logic [1:0]          w_len;
    logic [ROM_AW-1:0]   w_idx0;
    logic [ROM_AW-1:0]   w_idx1;
    logic [ROM_AW-1:0]   w_idx2;
    logic                w_unsup;
    logic                w_bc_ready;
    logic                w_last_slot;

    always_comb begin
        w_len   = 2'd0;
        w_idx0  = '0;
        w_idx1  = '0;
        w_idx2  = '0;
        w_unsup = 1'b0;
        unique case (bc_opcode)
            8'h00: ;
            8'h60: begin
                w_len  = 2'd3;
                w_idx0 = ROM_AW'(1);
                w_idx1 = ROM_AW'(2);
                w_idx2 = ROM_AW'(3);
            end
            8'h64: begin
                w_len  = 2'd3;
                w_idx0 = ROM_AW'(1);
                w_idx1 = ROM_AW'(4);
                w_idx2 = ROM_AW'(3);
            end
            default: w_unsup = 1'b1;
        endcase
    end

    assign w_bc_ready  = (r_state == S_IDLE) && !r_full;
    assign w_last_slot = (r_ptr == {CODE_AW{1'b1}});

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_step     <= 2'd0;
            r_len      <= 2'd0;
            r_rom_addr <= '0;
            r_nxt1     <= '0;
            r_nxt2     <= '0;
            r_ptr      <= '0;
            r_full     <= 1'b0;
            r_err      <= 1'b0;
        end else if (flush) begin
            r_state    <= S_IDLE;
            r_step     <= 2'd0;
            r_rom_addr <= '0;
            r_ptr      <= '0;
            r_full     <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bc_valid && w_bc_ready) begin
                        r_len      <= w_len;
                        r_step     <= 2'd0;
                        r_rom_addr <= w_idx0;
                        r_nxt1     <= w_idx1;
                        r_nxt2     <= w_idx2;
                        if (w_len != 2'd0)
                            r_state <= S_EMIT;
                        if (w_unsup)
                            r_err <= 1'b1;
                    end
                end
                S_EMIT: begin
                    if (emit_ready) begin
                        // The last buffer word is written; the rest of the template is dropped.
                        if (w_last_slot) begin
                            r_full  <= 1'b1;
                            r_state <= S_IDLE;
                        end else begin
                            r_ptr <= r_ptr + 1'b1;
                            if (r_step == r_len - 2'd1) begin
                                r_state <= S_IDLE;
                            end else begin
                                r_step     <= r_step + 2'd1;
                                r_rom_addr <= r_nxt1;
                                r_nxt1     <= r_nxt2;
                            end
                        end
                    end
                end
            endcase
        end
    end

    assign bc_ready   = w_bc_ready;
    assign rom_addr   = r_rom_addr;
    assign emit_valid = (r_state == S_EMIT);
    assign emit_addr  = r_ptr;
    assign emit_data  = rom_data;
    assign code_full  = r_full;
    assign err_unsup  = r_err;

endmodule

// File: tb/tb_jit_emit_seq.sv
// Bench for jit_emit_seq: directed vector table, hand sequences and a
// randomized run checked against a queue-based template model.
module tb_jit_emit_seq;

    localparam int ROM_AW  = 3;
    localparam int WORD_W  = 32;
    localparam int CODE_AW = 2;
    localparam int PMAX    = (1 << CODE_AW) - 1;

    logic               clk = 1'b0;
    logic               rst;
    logic               flush;
    logic               bc_valid;
    logic [7:0]         bc_opcode;
    logic               bc_ready;
    logic [ROM_AW-1:0]  rom_addr;
    logic [WORD_W-1:0]  rom_data;
    logic               emit_valid;
    logic               emit_ready;
    logic [CODE_AW-1:0] emit_addr;
    logic [WORD_W-1:0]  emit_data;
    logic               code_full;
    logic               err_unsup;

    int checks = 0;
    int errors = 0;

    // Model state
    logic [31:0] m_q[$];
    int          m_ptr;
    bit          m_full;
    bit          m_err;

    always #5 clk = ~clk;

    jit_emit_seq #(
        .ROM_AW (ROM_AW),
        .WORD_W (WORD_W),
        .CODE_AW(CODE_AW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .bc_valid  (bc_valid),
        .bc_opcode (bc_opcode),
        .bc_ready  (bc_ready),
        .rom_addr  (rom_addr),
        .rom_data  (rom_data),
        .emit_valid(emit_valid),
        .emit_ready(emit_ready),
        .emit_addr (emit_addr),
        .emit_data (emit_data),
        .code_full (code_full),
        .err_unsup (err_unsup)
    );

    always_comb begin
        case (rom_addr)
            3'd1:    rom_data = 32'hE83D0003;
            3'd2:    rom_data = 32'hE0800001;
            3'd3:    rom_data = 32'hE9AD0001;
            3'd4:    rom_data = 32'hE0400001;
            default: rom_data = 32'hDEAD0000 | {29'd0, rom_addr};
        endcase
    end

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_q.delete();
        m_ptr  = 0;
        m_full = 0;
        m_err  = 0;
    endtask

    task automatic model_step(input bit r, input bit f, input bit bv,
                              input logic [7:0] op, input bit er);
        if (r || f) begin
            model_reset();
        end else if (m_q.size() > 0) begin
            if (er) begin
                if (m_ptr == PMAX) begin
                    m_full = 1;
                    m_q.delete();
                end else begin
                    m_ptr++;
                    void'(m_q.pop_front());
                end
            end
        end else if (bv && !m_full) begin
            case (op)
                8'h00: ;
                8'h60: m_q = {32'hE83D0003, 32'hE0800001, 32'hE9AD0001};
                8'h64: m_q = {32'hE83D0003, 32'hE0400001, 32'hE9AD0001};
                default: m_err = 1;
            endcase
        end
    endtask

    task automatic model_check(input string tag);
        bit busy;
        busy = (m_q.size() > 0);
        chk({tag, ".bc_ready"}, 32'(bc_ready), 32'(!busy && !m_full));
        chk({tag, ".emit_valid"}, 32'(emit_valid), 32'(busy));
        chk({tag, ".emit_addr"}, 32'(emit_addr), 32'(m_ptr));
        if (busy)
            chk({tag, ".emit_data"}, emit_data, m_q[0]);
        chk({tag, ".code_full"}, 32'(code_full), 32'(m_full));
        chk({tag, ".err_unsup"}, 32'(err_unsup), 32'(m_err));
    endtask

    // One clock: drive, sample on negedge, advance the model, pass the edge.
    task automatic cyc(input bit r, input bit f, input bit bv,
                       input logic [7:0] op, input bit er, input string tag);
        rst        = r;
        flush      = f;
        bc_valid   = bv;
        bc_opcode  = op;
        emit_ready = er;
        @(negedge clk);
        model_check(tag);
        model_step(r, f, bv, op, er);
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        bit          fl;
        bit          bv;
        logic [7:0]  op;
        bit          er;
        bit          e_rdy;
        bit          e_vld;
        int          e_addr;
        logic [31:0] e_data;
        bit          e_full;
        bit          e_err;
    } vec_t;

    vec_t vt[$];

    initial begin
        // fl bv op er | rdy vld addr data full err
        vt.push_back('{0, 1, 8'h60, 1, 1, 0, 0, 32'h0, 0, 0});
        vt.push_back('{0, 0, 8'h00, 1, 0, 1, 0, 32'hE83D0003, 0, 0});
        vt.push_back('{0, 0, 8'h00, 1, 0, 1, 1, 32'hE0800001, 0, 0});
        vt.push_back('{0, 0, 8'h00, 1, 0, 1, 2, 32'hE9AD0001, 0, 0});
        vt.push_back('{0, 1, 8'h00, 1, 1, 0, 3, 32'h0, 0, 0});
        vt.push_back('{0, 1, 8'hB1, 1, 1, 0, 3, 32'h0, 0, 0});
        vt.push_back('{0, 1, 8'h64, 0, 1, 0, 3, 32'h0, 0, 1});
        vt.push_back('{0, 0, 8'h00, 0, 0, 1, 3, 32'hE83D0003, 0, 1});
        vt.push_back('{0, 0, 8'h00, 1, 0, 1, 3, 32'hE83D0003, 0, 1});
        vt.push_back('{1, 1, 8'h60, 0, 0, 0, 3, 32'h0, 1, 1});
        vt.push_back('{0, 0, 8'h00, 0, 1, 0, 0, 32'h0, 0, 0});

        rst = 1; flush = 0; bc_valid = 0; bc_opcode = 8'h00; emit_ready = 0;
        repeat (2) @(posedge clk);
        #1;
        model_reset();
        cyc(0, 0, 0, 8'h00, 0, "reset");

        for (int i = 0; i < vt.size(); i++) begin
            rst = 0; flush = vt[i].fl; bc_valid = vt[i].bv;
            bc_opcode = vt[i].op; emit_ready = vt[i].er;
            @(negedge clk);
            chk($sformatf("vec%0d.bc_ready", i), 32'(bc_ready), 32'(vt[i].e_rdy));
            chk($sformatf("vec%0d.emit_valid", i), 32'(emit_valid), 32'(vt[i].e_vld));
            chk($sformatf("vec%0d.emit_addr", i), 32'(emit_addr), 32'(vt[i].e_addr));
            if (vt[i].e_vld)
                chk($sformatf("vec%0d.emit_data", i), emit_data, vt[i].e_data);
            chk($sformatf("vec%0d.code_full", i), 32'(code_full), 32'(vt[i].e_full));
            chk($sformatf("vec%0d.err_unsup", i), 32'(err_unsup), 32'(vt[i].e_err));
            @(posedge clk);
            #1;
        end

        // Model now realigns with a reset.
        cyc(1, 0, 0, 8'h00, 0, "rst_sync");
        model_reset();

        // Backpressure on isub word 1.
        cyc(0, 0, 1, 8'h64, 1, "bp_acc");
        cyc(0, 0, 0, 8'h00, 1, "bp_w0");
        cyc(0, 0, 0, 8'h00, 0, "bp_hold0");
        cyc(0, 0, 0, 8'h00, 0, "bp_hold1");
        chk("bp.held_data", emit_data, 32'hE0400001);
        chk("bp.held_addr", 32'(emit_addr), 32'd1);
        cyc(0, 0, 0, 8'h00, 1, "bp_w1");
        cyc(0, 0, 0, 8'h00, 1, "bp_w2");
        cyc(0, 0, 0, 8'h00, 0, "bp_done");

        // Flush during word 1 of iadd, then restart at address 0.
        cyc(0, 1, 0, 8'h00, 0, "fl_pre");
        cyc(0, 0, 1, 8'h60, 1, "fl_acc");
        cyc(0, 0, 0, 8'h00, 1, "fl_w0");
        cyc(0, 1, 0, 8'h00, 1, "fl_w1");
        cyc(0, 0, 1, 8'h60, 1, "fl_idle");
        cyc(0, 0, 0, 8'h00, 1, "fl_re_w0");
        chk("fl.restart_addr", 32'(emit_addr), 32'd1);

        // Reset in the middle of a stalled sequence.
        cyc(0, 0, 0, 8'h00, 0, "rs_stall");
        cyc(1, 0, 0, 8'h00, 0, "rs_assert");
        cyc(0, 0, 0, 8'h00, 0, "rs_after");

        // Randomized run against the model.
        for (int n = 0; n < 4000; n++) begin
            logic [7:0] op;
            bit r, f, bv, er;
            case ($urandom_range(0, 5))
                0: op = 8'h00;
                1, 2: op = 8'h60;
                3: op = 8'h64;
                4: op = 8'hB1;
                default: op = 8'($urandom);
            endcase
            r  = ($urandom_range(0, 199) == 0);
            f  = ($urandom_range(0, 29) == 0);
            bv = $urandom_range(0, 1);
            er = ($urandom_range(0, 3) != 0);
            cyc(r, f, bv, op, er, "rnd");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
